// File: rtl/det_arbiter_if.sv
// Bundle between the requesters, the shared "101" detector and the det_arbiter scheduler.
// Handshake: req is a level sampled only while the arbiter is idle; bit_in[i] is consumed only in cycles where gnt[i]=1.
interface det_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int HIT_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] bit_in;
  logic [N_REQ-1:0] gnt;
  logic             det_a;
  logic             det_b;
  logic             busy;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic [HIT_W-1:0] hit_cnt;
  logic [2:0]       dbg_state;

  modport master (
    output req, bit_in, det_b,
    input  gnt, det_a, busy, done, done_id, hit_cnt, dbg_state
  );

  modport slave (
    input  req, bit_in, det_b,
    output gnt, det_a, busy, done, done_id, hit_cnt, dbg_state
  );
endinterface

// File: rtl/det_arbiter.sv
// Round-robin scheduler time-sharing one Moore "101" detector among N_REQ serial requesters.
// Each frame: FLUSH (2 zeros) -> STREAM (FRAME_LEN bits) -> DRAIN -> DONE (report hit count).
module det_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int HIT_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  det_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_win;
  logic [ID_W-1:0]  r_done_id;
  logic [ID_W-1:0]  w_pick;
  logic             w_any;
  logic [CNT_W-1:0] r_cnt;
  logic [HIT_W-1:0] r_hits;
  logic [HIT_W-1:0] r_hit_cnt;
  logic [HIT_W-1:0] w_hits_nxt;
  logic [N_REQ-1:0] w_gnt;
  logic             w_det_a;

  assign w_any = |bus.req;

  // Scan from lowest to highest priority so the last match left standing is the first requester at/after r_ptr.
  always_comb begin
    w_pick = r_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[r_ptr + ID_W'(i)]) w_pick = r_ptr + ID_W'(i);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_FLUSH;
      S_FLUSH:  if (r_cnt == CNT_W'(1)) w_next = S_STREAM;
      S_STREAM: if (r_cnt == CNT_W'(FRAME_LEN - 1)) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Only the granted requester reaches the detector; everyone else is masked off.
  always_comb begin
    w_gnt   = '0;
    w_det_a = 1'b0;
    if (r_state == S_STREAM) begin
      w_gnt[r_win] = 1'b1;
      w_det_a      = bus.bit_in[r_win];
    end
  end

  always_comb begin
    w_hits_nxt = r_hits;
    if (bus.det_b && (r_hits != {HIT_W{1'b1}})) w_hits_nxt = r_hits + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_win     <= '0;
      r_hits    <= '0;
      r_hit_cnt <= '0;
      r_done_id <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE:   if (w_any) r_win <= w_pick;
        S_FLUSH:  r_hits <= '0;
        S_STREAM: r_hits <= w_hits_nxt;
        S_DRAIN: begin
          r_hit_cnt <= w_hits_nxt;
          r_done_id <= r_win;
        end
        S_DONE:   r_ptr <= r_win + 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.det_a     = w_det_a;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.done_id   = r_done_id;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_det_arbiter.sv
// Bench for det_arbiter: frame-level reference model, scoreboard queue and per-cycle monitor.
module tb_det_arbiter;
  localparam int N_REQ = 4;
  localparam int FL    = 16;
  localparam int HIT_W = 8;
  localparam int ID_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  det_arbiter_if #(.N_REQ(N_REQ), .HIT_W(HIT_W)) bus ();

  det_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FL), .HIT_W(HIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- environment ----------------
  logic [FL-1:0]    frames [N_REQ];
  int               gcnt   [N_REQ];
  logic [N_REQ-1:0] noise;
  logic [N_REQ-1:0] drv_req;
  logic [N_REQ-1:0] drv_bits;
  logic [2:0]       hist = 3'b101;

  function automatic logic bit_at(logic [FL-1:0] f, int k);
    return f[FL-1-k];
  endfunction

  function automatic int ref_hits(logic [FL-1:0] f);
    int n = 0;
    for (int k = 2; k < FL; k++)
      if (bit_at(f, k-2) && !bit_at(f, k-1) && bit_at(f, k)) n++;
    if (n > (1 << HIT_W) - 1) n = (1 << HIT_W) - 1;
    return n;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      drv_bits[i] = bus.gnt[i] ? bit_at(frames[i], (gcnt[i] < FL) ? gcnt[i] : 0) : noise[i];
  end

  assign bus.bit_in = drv_bits;
  assign bus.req    = drv_req;
  assign bus.det_b  = (hist == 3'b101);

  always @(posedge clk) begin
    hist  <= {hist[1:0], bus.det_a};
    noise <= N_REQ'($urandom);
    for (int i = 0; i < N_REQ; i++) gcnt[i] <= bus.gnt[i] ? gcnt[i] + 1 : 0;
  end

  // ---------------- reference model ----------------
  logic [ID_W+HIT_W-1:0] exp_q[$];
  int   m_cnt = 0;
  int   m_win = 0;
  int   m_ptr = 0;
  logic m_last_rst = 1'b0;

  always @(posedge clk) begin
    m_last_rst = rst;
    if (rst) begin
      m_cnt = 0;
      m_ptr = 0;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (|drv_req) begin
        for (int i = N_REQ - 1; i >= 0; i--)
          if (drv_req[(m_ptr + i) % N_REQ]) m_win = (m_ptr + i) % N_REQ;
        exp_q.push_back({ID_W'(m_win), HIT_W'(ref_hits(frames[m_win]))});
        m_cnt = FL + 4;
        m_ptr = (m_win + 1) % N_REQ;
      end
    end else begin
      m_cnt = m_cnt - 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int   n_vec = 0;
  int   n_err = 0;
  int   wd_cnt = 0;
  int   wd_seen = 0;
  logic mon_en = 1'b0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;
  logic [HIT_W-1:0]      exp_hold;
  logic [ID_W+HIT_W-1:0] e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int p;
    logic stream;
    if (mon_en) begin
      if (m_last_rst) exp_hold = '0;
      p      = (m_cnt == 0) ? 0 : FL + 5 - m_cnt;
      stream = (p >= 3) && (p <= FL + 2);
      chk("busy",  32'(bus.busy), 32'(m_cnt != 0));
      chk("gnt",   32'(bus.gnt),  stream ? (32'd1 << m_win) : 32'd0);
      chk("det_a", 32'(bus.det_a), stream ? 32'(bit_at(frames[m_win], p - 3)) : 32'd0);
      chk("done",  32'(bus.done), 32'(p == FL + 4));
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("done_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("done_id", 32'(bus.done_id), 32'(e[ID_W+HIT_W-1:HIT_W]));
          chk("hit_cnt", 32'(bus.hit_cnt), 32'(e[HIT_W-1:0]));
          exp_hold = e[HIT_W-1:0];
        end
      end else begin
        chk("hit_hold", 32'(bus.hit_cnt), 32'(exp_hold));
      end
      if (wd_cnt != wd_seen) begin
        chk("wait_timeout", 32'(wd_cnt), 32'(wd_seen));
        wd_seen = wd_cnt;
      end
      if (end_req && !end_done) begin
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        end_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_busy();
    int c = 0;
    while (bus.busy !== 1'b1 && c < 20) begin step(); c++; end
    if (bus.busy !== 1'b1) wd_cnt++;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (bus.busy !== 1'b0 && c < 4 * (FL + 6)) begin step(); c++; end
    if (bus.busy !== 1'b0) wd_cnt++;
  endtask

  task automatic wait_gnt(int id);
    int c = 0;
    while (bus.gnt[id] !== 1'b1 && c < 2 * (FL + 6)) begin step(); c++; end
    if (bus.gnt[id] !== 1'b1) wd_cnt++;
  endtask

  task automatic run_one(logic [N_REQ-1:0] mask);
    drv_req = mask;
    wait_busy();
    drv_req = '0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int c;
    rst     = 1'b1;
    drv_req = '0;
    for (int i = 0; i < N_REQ; i++) frames[i] = '0;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // single frame with two overlapping matches
    frames[0] = 16'b1010100000000000;
    run_one(4'b0001);

    // frame boundary: trailing "10" then leading "1" must not combine
    frames[0] = 16'b0000000000000010;
    run_one(4'b0001);
    frames[1] = 16'b1000000000000000;
    run_one(4'b0010);

    // last-bit match, alternating, all ones
    frames[0] = 16'b0000000000000101;
    run_one(4'b0001);
    frames[2] = 16'b1010101010101010;
    run_one(4'b0100);
    frames[3] = 16'b1111111111111111;
    run_one(4'b1000);

    // all requesters held: rotation through five frames
    for (int i = 0; i < N_REQ; i++) frames[i] = FL'($urandom);
    drv_req = 4'b1111;
    dones = 0;
    c = 0;
    while (dones < 5 && c < 5 * (FL + 6) + 20) begin
      step();
      c++;
      if (bus.done === 1'b1) dones++;
    end
    if (dones < 5) wd_cnt++;
    drv_req = '0;
    wait_idle();

    // reset in the middle of requester 2's stream, request left high
    frames[2] = FL'($urandom);
    drv_req = 4'b0100;
    wait_gnt(2);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_busy();
    drv_req = '0;
    wait_idle();

    // request dropped mid-stream still completes the frame
    frames[1] = FL'($urandom);
    drv_req = 4'b0010;
    wait_gnt(1);
    step();
    drv_req = '0;
    wait_idle();

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      int hold;
      for (int i = 0; i < N_REQ; i++) frames[i] = FL'($urandom);
      drv_req = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      wait_busy();
      hold = $urandom_range(0, 40);
      repeat (hold) begin
        step();
        if ($urandom_range(0, 3) == 0) drv_req = N_REQ'($urandom);
      end
      drv_req = '0;
      wait_idle();
    end

    repeat (3) step();
    end_req = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
